// File: rtl/ysyx_23060184_lsu_pkg.sv
// Shared definitions for the load/store unit: widths, Funct3 codes, FSM encoding.
package ysyx_23060184_lsu_pkg;

  localparam int LSU_DW = 32;
  localparam int LSU_AW = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Byte-lane steering for the LSU: store mask/data replication, load extraction
// with sign/zero extension, and detection of misaligned or illegal accesses.
module ysyx_23060184_lsu_align
  import ysyx_23060184_lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic              is_store,
  input  logic [LSU_DW-1:0] wdata,
  input  logic [LSU_DW-1:0] rdata,
  output logic [3:0]        wmask,
  output logic [LSU_DW-1:0] wdata_lane,
  output logic [LSU_DW-1:0] load_data,
  output logic              err
);

  logic [LSU_DW-1:0] sh;

  // bring the addressed byte/halfword down to bit 0
  assign sh = rdata >> {addr_lo, 3'b000};

  // decode width code into lanes, extension and error flag
  always_comb begin
    wmask      = 4'b0000;
    wdata_lane = '0;
    load_data  = '0;
    err        = 1'b0;
    case (funct3)
      F3_B: begin
        wmask      = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        load_data  = {{24{sh[7]}}, sh[7:0]};
      end
      F3_H: begin
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_lane = {2{wdata[15:0]}};
        load_data  = {{16{sh[15]}}, sh[15:0]};
        err        = addr_lo[0];
      end
      F3_W: begin
        wmask      = 4'b1111;
        wdata_lane = wdata;
        load_data  = rdata;
        err        = |addr_lo;
      end
      // unsigned variants exist only for loads
      F3_BU: begin
        load_data = {24'b0, sh[7:0]};
        err       = is_store;
      end
      F3_HU: begin
        load_data = {16'b0, sh[15:0]};
        err       = is_store | addr_lo[0];
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Load/store unit: accepts one instruction per handshake, issues at most one
// req/gnt/rvalid bus transaction and hands the result to writeback.
//
// state  | meaning
// IDLE   | ready for a new instruction (Mready=1)
// REQ    | mem_req high, bus fields held until mem_gnt
// WAIT   | granted, waiting for mem_rvalid
// DONE   | Mvalid high, result held until Wready
module ysyx_23060184_lsu
  import ysyx_23060184_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DW,
  parameter int ADDR_WIDTH = LSU_AW
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  Evalid,
  output logic                  Mready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  Wready,
  output logic                  Mvalid,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Merr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t state_q, state_d;

  logic [2:0]            funct3_q;
  logic [1:0]            addr_lo_q;
  logic                  store_q;

  logic [2:0]            al_funct3;
  logic [1:0]            al_addr_lo;
  logic                  al_store;
  logic [3:0]            al_wmask;
  logic [DATA_WIDTH-1:0] al_wdata;
  logic [DATA_WIDTH-1:0] al_load;
  logic                  al_err;

  logic                  accept;
  logic                  non_mem;

  assign accept  = Evalid && (state_q == S_IDLE);
  assign non_mem = !MemRead && !MemWrite;

  // In IDLE the aligner checks the incoming instruction; afterwards it works
  // on the latched copy so load extraction uses the accepted Funct3/address.
  assign al_funct3  = (state_q == S_IDLE) ? Funct3         : funct3_q;
  assign al_addr_lo = (state_q == S_IDLE) ? ALUResult[1:0] : addr_lo_q;
  assign al_store   = (state_q == S_IDLE) ? MemWrite       : store_q;

  ysyx_23060184_lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_store   (al_store),
    .wdata      (WriteData),
    .rdata      (mem_rdata),
    .wmask      (al_wmask),
    .wdata_lane (al_wdata),
    .load_data  (al_load),
    .err        (al_err)
  );

  // Handshake/bus strobes decode straight from state so reset clears them at once.
  assign Mready  = (state_q == S_IDLE);
  assign Mvalid  = (state_q == S_DONE);
  assign mem_req = (state_q == S_REQ);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Evalid) begin
          if (non_mem || al_err) state_d = S_DONE;
          else                   state_d = S_REQ;
        end
      end
      S_REQ:   if (mem_gnt)    state_d = S_WAIT;
      S_WAIT:  if (mem_rvalid) state_d = S_DONE;
      S_DONE:  if (Wready)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // latch the instruction, bus fields and result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      funct3_q  <= 3'b000;
      addr_lo_q <= 2'b00;
      store_q   <= 1'b0;
      ReadData  <= '0;
      Merr      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= 4'b0000;
    end else begin
      if (accept) begin
        funct3_q  <= Funct3;
        addr_lo_q <= ALUResult[1:0];
        store_q   <= MemWrite;
        ReadData  <= '0;
        Merr      <= !non_mem && al_err;
        if (!non_mem && !al_err) begin
          mem_we    <= MemWrite;
          mem_addr  <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata <= MemWrite ? al_wdata : '0;
          mem_wmask <= MemWrite ? al_wmask : 4'b0000;
        end
      end else if ((state_q == S_WAIT) && mem_rvalid) begin
        ReadData <= store_q ? '0 : al_load;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Self-checking bench for the LSU: table of instructions with expected bus
// fields and results, plus hand-written reset sequences.
module tb_ysyx_23060184_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        Evalid = 1'b0;
  logic        Mready;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic        Wready = 1'b0;
  logic        Mvalid;
  logic [31:0] ReadData;
  logic        Merr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  ysyx_23060184_lsu dut (
    .clk        (clk),
    .rstn       (rstn),
    .Evalid     (Evalid),
    .Mready     (Mready),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Funct3     (Funct3),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .Wready     (Wready),
    .Mvalid     (Mvalid),
    .ReadData   (ReadData),
    .Merr       (Merr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          wb_dly;
    logic        exp_req;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int   tests = 0;
  int   failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // run one instruction through accept, bus, and writeback handshake
  task automatic do_op(input vec_t v);
    int          n;
    exp_t        e;
    logic [31:0] eaddr;
    eaddr = {v.addr[31:2], 2'b00};
    n = 0;
    while (!Mready && n < 20) begin tick(); n++; end
    chk("mready_before_accept", Mready, 1);
    Evalid = 1; MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    ALUResult = v.addr; WriteData = v.wd;
    e.rd = v.exp_rd; e.err = v.exp_err;
    sb.push_back(e);
    tick();
    Evalid = 0; MemRead = 0; MemWrite = 0; WriteData = $urandom; ALUResult = $urandom;
    chk("mready_after_accept", Mready, 0);
    chk("mem_req_after_accept", mem_req, v.exp_req);
    if (v.exp_req) begin
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_we", mem_we, v.wr);
      if (v.wr) begin
        chk("mem_wmask", mem_wmask, v.exp_mask);
        chk("mem_wdata", mem_wdata, v.exp_wdata);
      end
      for (int k = 0; k < v.gnt_dly; k++) begin
        tick();
        chk("req_held", mem_req, 1);
        chk("addr_held", mem_addr, eaddr);
        if (v.wr) chk("mask_held", mem_wmask, v.exp_mask);
      end
      mem_gnt = 1;
      tick();
      mem_gnt = 0;
      chk("req_drop_after_gnt", mem_req, 0);
      chk("mvalid_in_wait", Mvalid, 0);
      mem_rvalid = 1; mem_rdata = v.rdata;
      tick();
      mem_rvalid = 0; mem_rdata = $urandom;
    end
    chk("mvalid_latency", Mvalid, 1);
    n = 0;
    while (!Mvalid && n < 20) begin tick(); n++; end
    if (n == 20) chk("mvalid_timeout", Mvalid, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ReadData", ReadData, e.rd);
      chk("Merr", Merr, e.err);
      for (int k = 0; k < v.wb_dly; k++) begin
        tick();
        chk("mvalid_held", Mvalid, 1);
        chk("readdata_held", ReadData, e.rd);
        chk("merr_held", Merr, e.err);
        chk("mready_low_in_done", Mready, 0);
        chk("no_req_in_done", mem_req, 0);
      end
    end
    Wready = 1;
    tick();
    Wready = 0;
    chk("mvalid_after_wb", Mvalid, 0);
    chk("mready_after_wb", Mready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rd wr f3      addr          wd            rdata         gd wb req mask     wdata         rd            err
    vecs[0]  = '{0, 1, 3'b010, 32'h80000004, 32'hDEADBEEF, 32'h0,        2, 0, 1, 4'b1111, 32'hDEADBEEF, 32'h0,        0};
    vecs[1]  = '{0, 1, 3'b000, 32'h80000003, 32'h000000A5, 32'h0,        0, 1, 1, 4'b1000, 32'hA5A5A5A5, 32'h0,        0};
    vecs[2]  = '{1, 0, 3'b000, 32'h80000002, 32'h0,        32'h12F03456, 1, 0, 1, 4'b0000, 32'h0,        32'hFFFFFFF0, 0};
    vecs[3]  = '{1, 0, 3'b100, 32'h80000002, 32'h0,        32'h12F03456, 0, 0, 1, 4'b0000, 32'h0,        32'h000000F0, 0};
    vecs[4]  = '{1, 0, 3'b001, 32'h80000002, 32'h0,        32'h12F03456, 3, 0, 1, 4'b0000, 32'h0,        32'h000012F0, 0};
    vecs[5]  = '{1, 0, 3'b001, 32'h80000001, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[6]  = '{0, 0, 3'b010, 32'h00000013, 32'h12345678, 32'h0,        0, 3, 0, 4'b0000, 32'h0,        32'h0,        0};
    vecs[7]  = '{0, 1, 3'b001, 32'h80000012, 32'h1234ABCD, 32'h0,        1, 0, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0};
    vecs[8]  = '{1, 0, 3'b101, 32'h80000000, 32'h0,        32'h0000F00D, 0, 0, 1, 4'b0000, 32'h0,        32'h0000F00D, 0};
    vecs[9]  = '{1, 0, 3'b001, 32'h80000000, 32'h0,        32'h0000F00D, 0, 0, 1, 4'b0000, 32'h0,        32'hFFFFF00D, 0};
    vecs[10] = '{1, 0, 3'b010, 32'h80000100, 32'h0,        32'hCAFEBABE, 2, 2, 1, 4'b0000, 32'h0,        32'hCAFEBABE, 0};
    vecs[11] = '{1, 0, 3'b011, 32'h80000000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[12] = '{0, 1, 3'b100, 32'h80000000, 32'h11,       32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0,        1};
    vecs[13] = '{1, 1, 3'b000, 32'h80000001, 32'h0000003C, 32'h0,        0, 0, 1, 4'b0010, 32'h3C3C3C3C, 32'h0,        0};
    vecs[14] = '{1, 0, 3'b000, 32'h80000001, 32'h0,        32'h00007F00, 1, 0, 1, 4'b0000, 32'h0,        32'h0000007F, 0};

    #12;
    chk("rst_mready", Mready, 1);
    chk("rst_mvalid", Mvalid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 4'b0000);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_merr", Merr, 0);
    #4 rstn = 1;
    tick();

    for (int i = 0; i < 15; i++) do_op(vecs[i]);

    // reset while a request is pending: mem_req must drop without a clock
    Evalid = 1; MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h80000040;
    tick();
    Evalid = 0; MemRead = 0;
    chk("rst_req_pending", mem_req, 1);
    #2 rstn = 0;
    #1;
    chk("async_rst_req_drop", mem_req, 0);
    chk("async_rst_mready", Mready, 1);
    #2 rstn = 1;
    tick();

    // reset while waiting for rvalid, then a stray rvalid in IDLE
    Evalid = 1; MemRead = 1; Funct3 = 3'b010; ALUResult = 32'h80000044;
    tick();
    Evalid = 0; MemRead = 0;
    mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("in_wait_req_low", mem_req, 0);
    chk("in_wait_mready", Mready, 0);
    #2 rstn = 0;
    #1;
    chk("wait_rst_mvalid", Mvalid, 0);
    chk("wait_rst_mem_req", mem_req, 0);
    chk("wait_rst_mready", Mready, 1);
    #2 rstn = 1;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 0;
    chk("stray_rvalid_mvalid", Mvalid, 0);
    chk("stray_rvalid_mready", Mready, 1);
    chk("stray_rvalid_readdata", ReadData, 32'h0);
    tick();
    chk("stray_rvalid_mvalid_2", Mvalid, 0);

    do_op('{1, 0, 3'b100, 32'h80000003, 32'h0, 32'h9A000000, 1, 1, 1, 4'b0000, 32'h0, 32'h0000009A, 0});

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
